// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: PC/instruction widths, NOP encoding,
// fetch FSM states and the IF/ID pipeline payload.
package cpu_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h4000;

    typedef enum logic [1:0] {
        BOOT_HI,
        BOOT_LO,
        RUN
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instruction;
        logic [INSTR_W-1:0] imm;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, decode/execute/memory controls
// and the IF/ID outputs seen by decode.
interface fetch_stage_if #(
    parameter int unsigned IMEM_AW = 20
) ();
    import cpu_pkg::*;

    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall_fetch_from_cu;
    logic               clear_instruction;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               pc_choose_memory;
    logic [PC_W-1:0]    mem_pc;
    logic [INSTR_W-1:0] if_instruction;
    logic [INSTR_W-1:0] if_imm;
    logic [PC_W-1:0]    if_pc;
    logic               if_valid;
    logic               booting;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall_fetch_from_cu,
        input  clear_instruction,
        input  branch_taken,
        input  branch_target,
        input  pc_choose_memory,
        input  mem_pc,
        output if_instruction,
        output if_imm,
        output if_pc,
        output if_valid,
        output booting
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall_fetch_from_cu,
        output clear_instruction,
        output branch_taken,
        output branch_target,
        output pc_choose_memory,
        output mem_pc,
        input  if_instruction,
        input  if_imm,
        input  if_pc,
        input  if_valid,
        input  booting
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > ldm > load > hold.
// ldm loads imm/pc but inserts a NOP (immediate-word capture).
module if_id_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               ldm,
    input  logic               flush,
    input  logic [INSTR_W-1:0] word,
    input  logic [PC_W-1:0]    pc_next,
    output if_id_t             q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.instruction <= NOP_INSTR;
            q.imm         <= '0;
            q.pc          <= '0;
            q.valid       <= 1'b0;
        end else if (flush) begin
            q.instruction <= NOP_INSTR;
            q.valid       <= 1'b0;
        end else if (ldm) begin
            q.instruction <= NOP_INSTR;
            q.imm         <= word;
            q.pc          <= pc_next;
            q.valid       <= 1'b0;
        end else if (load) begin
            q.instruction <= word;
            q.imm         <= word;
            q.pc          <= pc_next;
            q.valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, redirect muxing and IF/ID load control.
// FETCH_BOOT_VECTOR_EN selects booting the PC from a two-word vector in imem.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned        IMEM_AW      = 20,
    parameter logic [IMEM_AW-1:0] RST_VEC_ADDR = '0,
    parameter logic [PC_W-1:0]    RESET_PC     = '0
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    run_pc_d;
    logic [IMEM_AW-1:0] imem_addr_c;
    logic               redirect;
    logic               run_load;
    logic               run_ldm;
    logic               run_flush;
    logic               ifid_load;
    logic               ifid_ldm;
    logic               ifid_flush;
    if_id_t             ifid_q;

    assign pc_inc   = pc_q + PC_W'(1);
    assign redirect = bus.pc_choose_memory | bus.branch_taken;

    // Steady-state PC and IF/ID control; a redirect overrides stall and clear.
    always_comb begin : run_mux
        run_pc_d  = pc_inc;
        if (bus.pc_choose_memory) begin
            run_pc_d = bus.mem_pc;
        end else if (bus.branch_taken) begin
            run_pc_d = bus.branch_target;
        end else if (bus.stall_fetch_from_cu) begin
            run_pc_d = pc_q;
        end
        run_flush = redirect;
        run_ldm   = !redirect && bus.clear_instruction;
        run_load  = !redirect && !bus.clear_instruction && !bus.stall_fetch_from_cu;
    end

`ifdef FETCH_BOOT_VECTOR_EN
    localparam logic [PC_W-1:0] PC_RST = '0;

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [INSTR_W-1:0] hi_q;
    logic [INSTR_W-1:0] hi_d;
    logic               booting_q;
    logic               unused_cfg;

    assign unused_cfg = ^RESET_PC;

    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            state_q   <= BOOT_HI;
            booting_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            booting_q <= (state_d != RUN);
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            BOOT_HI: state_d = BOOT_LO;
            BOOT_LO: state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT_HI;
        endcase
    end

    // Boot states fetch the vector and ignore every pipeline control.
    always_comb begin : fsm_outputs
        imem_addr_c = pc_q[IMEM_AW-1:0];
        pc_d        = pc_q;
        hi_d        = hi_q;
        ifid_load   = 1'b0;
        ifid_ldm    = 1'b0;
        ifid_flush  = 1'b0;
        case (state_q)
            BOOT_HI: begin
                imem_addr_c = RST_VEC_ADDR;
                hi_d        = bus.imem_rdata;
            end
            BOOT_LO: begin
                imem_addr_c = IMEM_AW'(RST_VEC_ADDR + IMEM_AW'(1));
                pc_d        = {hi_q, bus.imem_rdata};
            end
            RUN: begin
                pc_d       = run_pc_d;
                ifid_load  = run_load;
                ifid_ldm   = run_ldm;
                ifid_flush = run_flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin : hi_reg
        if (!reset) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

    assign bus.booting = booting_q;
`else
    localparam logic [PC_W-1:0] PC_RST = RESET_PC;

    logic unused_cfg;

    assign unused_cfg  = ^RST_VEC_ADDR;
    assign imem_addr_c = pc_q[IMEM_AW-1:0];
    assign pc_d        = run_pc_d;
    assign ifid_load   = run_load;
    assign ifid_ldm    = run_ldm;
    assign ifid_flush  = run_flush;
    assign bus.booting = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin : pc_reg
        if (!reset) begin
            pc_q <= PC_RST;
        end else begin
            pc_q <= pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (ifid_load),
        .ldm     (ifid_ldm),
        .flush   (ifid_flush),
        .word    (bus.imem_rdata),
        .pc_next (pc_inc),
        .q       (ifid_q)
    );

    assign bus.imem_addr      = imem_addr_c;
    assign bus.if_instruction = ifid_q.instruction;
    assign bus.if_imm         = ifid_q.imm;
    assign bus.if_pc          = ifid_q.pc;
    assign bus.if_valid       = ifid_q.valid;

endmodule
